// File: rtl/rs_chien_search_if.sv
// Port bundle for the RS(255,251) Chien search stage.
//
// Handshake: `start` is a one-cycle request pulse and is honoured only when
// the stage is idle; lambda1/lambda2/deg are sampled on that same edge.
// `done` is a one-cycle completion pulse. error_num/el1/el2/pos1/pos2/fail
// are valid from the `done` cycle and hold until the next honoured start.
// `dbg_state` mirrors the FSM state for observation only.
interface rs_chien_search_if;
    logic       start;
    logic [7:0] lambda1;
    logic [7:0] lambda2;
    logic [1:0] deg;
    logic       busy;
    logic       done;
    logic [2:0] error_num;
    logic [7:0] el1;
    logic [7:0] el2;
    logic [7:0] pos1;
    logic [7:0] pos2;
    logic       fail;
    logic [1:0] dbg_state;

    modport master (
        output start, lambda1, lambda2, deg,
        input  busy, done, error_num, el1, el2, pos1, pos2, fail, dbg_state
    );

    modport slave (
        input  start, lambda1, lambda2, deg,
        output busy, done, error_num, el1, el2, pos1, pos2, fail, dbg_state
    );
endinterface

// File: rtl/rs_chien_search.sv
// Chien search for the RS(255,251) decoder (t=2), GF(2^8) poly 0x11D, alpha=0x02.
// Evaluates Lambda(x)=1+l1*x+l2*x^2 at x=alpha^i for i=0..N-1, one point per
// cycle, recording up to two roots (el = alpha^i, pos = (255-i) mod 255).
// Optional macro CHIEN_EARLY_EXIT_EN: leave the search as soon as the number
// of roots found equals the polynomial degree.
module rs_chien_search #(
    parameter int N = 255
) (
    input logic           clk,
    input logic           rst_n,
    rs_chien_search_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [7:0] LAST_I = 8'(N - 1);

    state_t     state;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] alpha_i;
    logic [7:0] idx;
    logic [1:0] deg_r;
    logic [1:0] cnt;

    logic       busy_r;
    logic       done_r;
    logic [2:0] error_num_r;
    logic [7:0] el1_r;
    logic [7:0] el2_r;
    logic [7:0] pos1_r;
    logic [7:0] pos2_r;
    logic       fail_r;

    logic       is_root;
    logic [1:0] cnt_next;
    logic [7:0] pos_now;
    logic       finish_now;

    // Multiply by alpha: shift left and reduce by 0x11D.
    function automatic logic [7:0] mul_a(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    endfunction

    // Root test at the current point, saturating root count and position.
    always_comb begin
        is_root  = ((8'h01 ^ r1 ^ r2) == 8'h00);
        cnt_next = (is_root && (cnt != 2'd3)) ? cnt + 2'd1 : cnt;
        pos_now  = (idx == 8'd0) ? 8'd0 : 8'd255 - idx;
    end

`ifdef CHIEN_EARLY_EXIT_EN
    assign finish_now = (idx == LAST_I) || (cnt_next == deg_r);
`else
    assign finish_now = (idx == LAST_I);
`endif

    // Control FSM with registered outputs and the evaluation datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            r1          <= 8'h00;
            r2          <= 8'h00;
            alpha_i     <= 8'h00;
            idx         <= 8'h00;
            deg_r       <= 2'd0;
            cnt         <= 2'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_num_r <= 3'd0;
            el1_r       <= 8'h00;
            el2_r       <= 8'h00;
            pos1_r      <= 8'h00;
            pos2_r      <= 8'h00;
            fail_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        el1_r       <= 8'h00;
                        el2_r       <= 8'h00;
                        pos1_r      <= 8'h00;
                        pos2_r      <= 8'h00;
                        error_num_r <= 3'd0;
                        fail_r      <= 1'b0;
                        case (bus.deg)
                            2'd0: begin
                                state  <= FINISH;
                                done_r <= 1'b1;
                            end
                            2'd3: begin
                                state  <= FINISH;
                                done_r <= 1'b1;
                                fail_r <= 1'b1;
                            end
                            default: begin
                                state   <= SEARCH;
                                busy_r  <= 1'b1;
                                r1      <= bus.lambda1;
                                r2      <= bus.lambda2;
                                alpha_i <= 8'h01;
                                idx     <= 8'h00;
                                cnt     <= 2'd0;
                                deg_r   <= bus.deg;
                            end
                        endcase
                    end
                end
                SEARCH: begin
                    if (is_root && (cnt == 2'd0)) begin
                        el1_r  <= alpha_i;
                        pos1_r <= pos_now;
                    end else if (is_root && (cnt == 2'd1)) begin
                        el2_r  <= alpha_i;
                        pos2_r <= pos_now;
                    end
                    cnt     <= cnt_next;
                    r1      <= mul_a(r1);
                    r2      <= mul_a(mul_a(r2));
                    alpha_i <= mul_a(alpha_i);
                    idx     <= idx + 8'd1;
                    if (finish_now) begin
                        state  <= FINISH;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        if (cnt_next == deg_r) begin
                            error_num_r <= {1'b0, cnt_next};
                            fail_r      <= 1'b0;
                        end else begin
                            error_num_r <= 3'd0;
                            fail_r      <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.error_num = error_num_r;
    assign bus.el1       = el1_r;
    assign bus.el2       = el2_r;
    assign bus.pos1      = pos1_r;
    assign bus.pos2      = pos2_r;
    assign bus.fail      = fail_r;
    assign bus.dbg_state = state;

endmodule

// File: doc/rs_chien_search.md
Name: rs_chien_search

Overview:
- Chien search stage of the RS(255,251) decoder (t=2). Sits between the key-equation solver and the Forney stage.
- Takes the error-locator polynomial Λ(x)=1+λ1·x+λ2·x² and its degree.
- Tests x=α^i for i=0..N-1 and records each root as an error-location value el = α^i. The error locator is 1/el; the codeword position is (255−i) mod 255.
- Results feed the Forney stage. `done` drives Forney's `start`; `error_num`, `el1` and `el2` drive its matching inputs.

Parameters:
- N, 255, number of candidate roots searched (i=0..N−1); legal range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches lambda1, lambda2, deg
- lambda1  in  8  Λ coefficient of x
- lambda2  in  8  Λ coefficient of x²
- deg  in  2  degree of Λ (0..2); 3 is treated as fail
- busy  out  1  high while searching
- done  out  1  one-cycle pulse; result outputs valid from this cycle
- error_num  out  3  number of errors located (0..2); 0 on fail
- el1  out  8  first root found (lowest i)
- el2  out  8  second root found
- pos1  out  8  codeword position of el1, (255−i) mod 255
- pos2  out  8  codeword position of el2
- fail  out  1  roots found ≠ deg (uncorrectable)

Behaviour:
- Reset: busy=0, done=0, error_num=0, el1=el2=0, pos1=pos2=0, fail=0. State IDLE, all internal registers 0.
- GF(2^8) arithmetic uses primitive polynomial 0x11D, α=0x02. Multiplication is by constants only (α, α²); there is no general multiplier.
- States: IDLE, SEARCH, FINISH.
- IDLE → SEARCH:
  - On start with deg∈{1,2}.
  - Load r1=λ1, r2=λ2, i=0, root count=0. Clear el/pos/fail/error_num.
- IDLE → FINISH:
  - On start with deg=0: error_num=0, fail=0.
  - On start with deg=3: fail=1, error_num=0.
- SEARCH, every cycle:
  - sum = 1 ^ r1 ^ r2. sum==0 means α^i is a root.
  - On a root with count 0: el1=α^i, pos1=(255−i) mod 255. On a root with count 1: write el2/pos2 instead.
  - Count saturates at 3; more than 2 roots does not overwrite el1/el2.
  - Update r1←r1·α, r2←r2·α², track α^i (starts 0x01, ×α per cycle), i←i+1.
- SEARCH → FINISH: after the i=N−1 test.
- FINISH:
  - Single cycle: done=1, busy=0, return to IDLE.
  - count==deg: error_num=count, fail=0.
  - Otherwise: error_num=0, fail=1. el/pos keep whatever was captured.
- Latency: start sampled at edge k. Searches occupy cycles k+1..k+N. done is high in cycle k+N+1 (N=255 gives 256 cycles). With deg=0/3, done is high in cycle k+1.
- busy=1 from cycle after start through the last SEARCH cycle.
- start while busy or in FINISH is ignored; inputs are not re-latched.
- Result outputs hold until the next accepted start.
- Reset mid-search aborts immediately to the reset values above; no done is produced.
- A repeated root (e.g. Λ=(1+x)²) is detected once, so count=1 with deg=2, which gives fail=1.

Optional Feature:
- Macro CHIEN_EARLY_EXIT_EN.
- Defined:
  - SEARCH → FINISH as soon as count reaches deg. done comes the cycle after the deciding root.
  - Example: roots at i=0 and i=3 with deg=2 gives done at k+5.
  - Fail cases still run the full N cycles.
- Undefined: always the full N search cycles, giving fixed latency N+1.

Test Plan:
- Single error at position 0: start, deg=1, λ1=0x01 → done at k+256; error_num=1, el1=0x01, pos1=0, fail=0.
- Single error at position 1: deg=1, λ1=0x02 → root at i=254; el1=0x8E, pos1=1, error_num=1.
- Two errors at positions 0,1: deg=2, λ1=0x03, λ2=0x02 → el1=0x01/pos1=0, el2=0x8E/pos2=1, error_num=2, fail=0. With CHIEN_EARLY_EXIT_EN, done at k+256 (last root at i=254).
- Repeated root: deg=2, λ1=0x00, λ2=0x01 → fail=1, error_num=0, el1=0x01.
- deg=0 → done at k+1, error_num=0, fail=0, busy never high. deg=3 → done at k+1, fail=1.
- Robustness:
  - A second start at k+50 during a search is ignored; the first result is unchanged.
  - rst_n low at k+100 → all outputs 0, no done; the next start works normally.
